button_irq_conditioner: RTL

//  Conditions the raw external push-button before it reaches the soft-processor interrupt input.
//  - Synchronizes the button, debounces it and detects the press edge.
//  - Raises a level interrupt request that stays high until the processor acknowledges it.
//  - Sits directly upstream of the processor subsystem: irq drives external_intrp, and the

---
 rtl/button_irq_conditioner.sv | 110 +++++++++++
 1 files changed

// File: rtl/button_irq_conditioner.sv
// Push-button conditioner: synchronize, debounce, press-edge detect, level IRQ with ack/overrun.
// Optional macro BTN_RELEASE_IRQ_EN: the release edge also raises irq.
module button_irq_conditioner #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       ext_rst,
    input  logic       btn_in,
    input  logic       intr_ack,
    output logic       irq,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic       irq_overrun
);

    localparam int unsigned DEBOUNCE_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned CNT_W        = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic [CNT_W-1:0]       db_cnt;
    logic                   level_d;
    logic                   press_evt;
    logic                   fsm_evt;
    state_t                 state_q;
    state_t                 state_d;
    logic                   irq_d;
    logic                   overrun_d;

    // Metastability chain for the asynchronous button
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Level only changes after btn_s has disagreed for DEBOUNCE_CYC consecutive cycles
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (btn_s == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            db_cnt    <= '0;
            btn_level <= btn_s;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) level_d <= 1'b0;
        else         level_d <= btn_level;
    end

    assign press_evt = btn_level & ~level_d;

`ifdef BTN_RELEASE_IRQ_EN
    logic rel_evt;
    assign rel_evt = ~btn_level & level_d;
    assign fsm_evt = press_evt | rel_evt;
`else
    assign fsm_evt = press_evt;
`endif

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst)                               press_count <= 8'h00;
        else if (press_evt && press_count != 8'hFF) press_count <= press_count + 8'd1;
    end

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_q     <= IDLE;
            irq         <= 1'b0;
            irq_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq         <= irq_d;
            irq_overrun <= overrun_d;
        end
    end

    // An ack coinciding with a new event keeps the request pending
    always_comb begin
        state_d   = state_q;
        overrun_d = irq_overrun;
        case (state_q)
            IDLE: begin
                if (fsm_evt) state_d = PENDING;
            end
            PENDING: begin
                if (intr_ack && !fsm_evt)      state_d   = IDLE;
                else if (fsm_evt && !intr_ack) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == PENDING);
    end

endmodule
